// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter: FWFT FIFO read side to valid/ready stream via 2-entry buffer; FIFO_RD_STATS_EN adds word_cnt.
`ifndef DSIZE
`define DSIZE 8
`endif
module fifo_rd_stream_adapter #(
    parameter int DSIZE = `DSIZE
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             drain_en,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic             m_valid,
    output logic [DSIZE-1:0] m_data,
    input  logic             m_ready,
    output logic [1:0]       occupancy
`ifdef FIFO_RD_STATS_EN
    ,output logic [15:0]     word_cnt
`endif
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t           r_state, w_next;
    logic [DSIZE-1:0] r_head, r_tail, w_head, w_tail;
    logic             w_push, w_pop;
    assign w_push    = !rrst && drain_en && !rempty && (r_state != FULL);
    assign w_pop     = m_valid && m_ready;
    assign rinc      = w_push;
    assign m_valid   = (r_state != EMPTY);
    assign m_data    = r_head;
    assign occupancy = r_state;
    always_comb begin
        w_next = state_t'(2'(r_state + {1'b0, w_push} - {1'b0, w_pop}));
        w_head = ((r_state == EMPTY || (r_state == ONE && w_pop)) && w_push) ? rdata :
                 (r_state == FULL && w_pop) ? r_tail : r_head;
        w_tail = (r_state == ONE && w_push && !w_pop) ? rdata : r_tail;
    end
    always_ff @(posedge rclk) begin
        if (rrst) r_state <= EMPTY;
        else r_state <= w_next;
    end
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_head <= w_head;
            r_tail <= w_tail;
        end
    end
`ifdef FIFO_RD_STATS_EN
    logic [15:0] r_word_cnt;
    always_ff @(posedge rclk) begin
        if (rrst) r_word_cnt <= '0;
        else r_word_cnt <= r_word_cnt + 16'(w_pop);
    end
    assign word_cnt = r_word_cnt;
`endif
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// tb_fifo_rd_stream_adapter: directed and random checks against a queue-based model of the adapter.
module tb_fifo_rd_stream_adapter;
    localparam int W = 8;
    logic         rclk = 1'b0;
    logic         rrst, drain_en, rempty, m_ready, rinc, m_valid;
    logic [W-1:0] rdata, m_data;
    logic [1:0]   occupancy;
`ifdef FIFO_RD_STATS_EN
    logic [15:0]  word_cnt;
`endif
    int           n_tests = 0;
    int           n_fail = 0;
    int           rinc_cnt = 0;
    int           xfer = 0;
    logic [W-1:0] up[$];
    logic [W-1:0] bq[$];

    fifo_rd_stream_adapter #(.DSIZE(W)) dut (
        .rclk(rclk), .rrst(rrst), .drain_en(drain_en), .rempty(rempty), .rdata(rdata),
        .rinc(rinc), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .occupancy(occupancy)
`ifdef FIFO_RD_STATS_EN
        , .word_cnt(word_cnt)
`endif
    );

    always #5 rclk = ~rclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic e_rinc, e_pop;
        rempty = (up.size() == 0);
        rdata  = rempty ? W'($urandom) : up[0];
        #1;
        e_rinc = !rrst && drain_en && !rempty && (bq.size() < 2);
        e_pop  = (bq.size() > 0) && m_ready;
        check("rinc", {31'd0, rinc}, {31'd0, e_rinc});
        if (rinc) rinc_cnt++;
        @(posedge rclk);
        #1;
        if (rrst) begin
            bq.delete();
            xfer = 0;
        end else begin
            if (e_pop) begin
                void'(bq.pop_front());
                xfer++;
            end
            if (e_rinc) bq.push_back(up.pop_front());
        end
        check("m_valid", {31'd0, m_valid}, {31'd0, bq.size() > 0});
        check("occupancy", {30'd0, occupancy}, 32'(bq.size()));
        if (rrst) check("m_data_rst", {24'd0, m_data}, 32'd0);
        else if (bq.size() > 0) check("m_data", {24'd0, m_data}, {24'd0, bq[0]});
    endtask

    initial begin
        rrst = 1'b1; drain_en = 1'b1; m_ready = 1'b1;
        up.push_back(8'hAA);
        repeat (2) cycle();
        check("reset_up_intact", 32'(up.size()), 32'd1);
        up.delete();
        rrst = 1'b0;
        // streaming
        up = '{8'h11, 8'h22, 8'h33};
        rinc_cnt = 0;
        repeat (5) cycle();
        check("stream_rinc_cnt", 32'(rinc_cnt), 32'd3);
        // backpressure
        m_ready = 1'b0;
        up = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        rinc_cnt = 0;
        repeat (4) cycle();
        check("bp_rinc_cnt", 32'(rinc_cnt), 32'd2);
        check("bp_occ", {30'd0, occupancy}, 32'd2);
        check("bp_head", {24'd0, m_data}, 32'hA1);
        m_ready = 1'b1;
        repeat (5) cycle();
        // push and pop together in ONE
        up = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("one_occ", {30'd0, occupancy}, 32'd1);
        end
        cycle();
        check("one_drained", {30'd0, occupancy}, 32'd0);
        // mid-stream reset while full
        m_ready = 1'b0;
        up = '{8'hC1, 8'hC2, 8'hC3};
        repeat (3) cycle();
        check("pre_rst_occ", {30'd0, occupancy}, 32'd2);
        rrst = 1'b1;
        cycle();
        rrst = 1'b0;
        m_ready = 1'b1;
        up.push_back(8'hD1);
        up.push_back(8'hD2);
        cycle();
        check("post_rst_fresh", {24'd0, m_data}, 32'hC3);
        repeat (4) cycle();
        // random traffic
        for (int i = 0; i < 500; i++) begin
            drain_en = ($urandom_range(0, 3) != 0);
            m_ready  = ($urandom_range(0, 2) != 0);
            rrst     = ($urandom_range(0, 59) == 0);
            if (up.size() < 4 && $urandom_range(0, 1) == 1) up.push_back(W'($urandom));
            cycle();
        end
        rrst = 1'b0;
`ifdef FIFO_RD_STATS_EN
        rrst = 1'b1; up.delete();
        cycle();
        rrst = 1'b0; drain_en = 1'b1; m_ready = 1'b1;
        while (xfer < 32'h10000) begin
            if (up.size() < 2) up.push_back(W'($urandom));
            cycle();
        end
        check("word_cnt_wrap", {16'd0, word_cnt}, 32'h0);
        while (xfer < 32'h10003) begin
            if (up.size() < 2) up.push_back(W'($urandom));
            cycle();
        end
        check("word_cnt_3", {16'd0, word_cnt}, 32'h3);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
